// File: rtl/shift_seq_ctrl.sv
// Two-requester round-robin word serialiser: grants one requester, shifts its word out MSB first.
// Optional even-parity trailer bit when SHIFT_SEQ_PARITY_EN is defined.
module shift_seq_ctrl #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req0,
    input  logic [DATA_W-1:0] din0,
    input  logic              req1,
    input  logic [DATA_W-1:0] din1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sdo,
    output logic              sdo_vld,
    output logic              owner,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W);

`ifdef SHIFT_SEQ_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2, PAR = 2'd3} state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  sreg_q, sreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               owner_q, owner_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               sdo_q, sdo_d;
    logic               vld_q, vld_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pick;
`ifdef SHIFT_SEQ_PARITY_EN
    logic               par_q, par_d;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            sdo_q   <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            sdo_q   <= sdo_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SHIFT_SEQ_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Outputs are computed from the next state so every output port comes straight from a flop.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        sdo_d   = 1'b0;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        pick    = 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    // On a tie the requester not served last wins.
                    pick    = (req0 & req1) ? ~last_q : req1;
                    sreg_d  = pick ? din1 : din0;
                    owner_d = pick;
                    last_d  = pick;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    cnt_d   = '0;
                    sdo_d   = sreg_d[DATA_W-1];
                    vld_d   = 1'b1;
                    state_d = SHIFT;
`ifdef SHIFT_SEQ_PARITY_EN
                    par_d   = even_parity(sreg_d);
`endif
                end
            end
            SHIFT: begin
                sreg_d = sreg_q << 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef SHIFT_SEQ_PARITY_EN
                    sdo_d   = par_q;
                    vld_d   = 1'b1;
                    state_d = PAR;
`else
                    done_d  = 1'b1;
                    state_d = DONE;
`endif
                end else begin
                    sdo_d = sreg_d[DATA_W-1];
                    vld_d = 1'b1;
                end
            end
`ifdef SHIFT_SEQ_PARITY_EN
            PAR: begin
                done_d  = 1'b1;
                state_d = DONE;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign sdo     = sdo_q;
    assign sdo_vld = vld_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl; expected bits and grants are queued as stimulus is driven.
module tb_shift_seq_ctrl;

`ifdef SHIFT_SEQ_PARITY_EN
    localparam int FRAME = 7;
`else
    localparam int FRAME = 6;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [3:0] din0 = 4'h0;
    logic [3:0] din1 = 4'h0;
    logic       gnt0, gnt1, sdo, sdo_vld, owner, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_done   = 0;
    int done_ref;
    bit exp_bits[$];
    bit exp_gnt[$];
    int gnt_cyc[$];

    shift_seq_ctrl dut (
        .clk(clk), .clr(clr),
        .req0(req0), .din0(din0), .req1(req1), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1), .sdo(sdo), .sdo_vld(sdo_vld),
        .owner(owner), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_frame(input bit who, input logic [3:0] d);
        for (int i = 3; i >= 0; i--) exp_bits.push_back(d[i]);
`ifdef SHIFT_SEQ_PARITY_EN
        exp_bits.push_back(^d);
`endif
        exp_gnt.push_back(who);
    endtask

    // One clock; outputs are sampled 1 ns after the rising edge and scored.
    task automatic step();
        bit w;
        @(posedge clk);
        #1;
        cyc++;
        if (sdo_vld) begin
            if (exp_bits.size() == 0) check_eq("sdo_unexpected", 32'd1, 32'd0);
            else check_eq("sdo_bit", sdo, exp_bits.pop_front());
        end
        if (gnt0 | gnt1) begin
            if (exp_gnt.size() == 0) check_eq("gnt_unexpected", {gnt1, gnt0}, 32'd0);
            else begin
                w = exp_gnt.pop_front();
                check_eq("gnt_sel", {gnt1, gnt0}, w ? 32'd2 : 32'd1);
                check_eq("gnt_owner", owner, w);
                gnt_cyc.push_back(cyc);
            end
        end
        if (done) begin
            n_done++;
            check_eq("done_sdo_vld", sdo_vld, 32'd0);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"}, busy, 32'd0);
        check_eq({tag, "_sdo"}, sdo, 32'd0);
        check_eq({tag, "_vld"}, sdo_vld, 32'd0);
        check_eq({tag, "_gnt"}, {gnt1, gnt0}, 32'd0);
        check_eq({tag, "_done"}, done, 32'd0);
    endtask

    task automatic do_reset();
        clr = 1'b0;
        #1;
        check_quiet("rst");
        check_eq("rst_owner", owner, 32'd0);
        step();
        clr = 1'b1;
    endtask

    task automatic single(input bit who, input logic [3:0] d);
        push_frame(who, d);
        if (who) begin req1 = 1'b1; din1 = d; end
        else begin req0 = 1'b1; din0 = d; end
        step();
        check_eq("single_busy_first", busy, 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (FRAME - 3) begin
            step();
            check_eq("single_busy", busy, 32'd1);
        end
        step();
        check_eq("single_done", done, 32'd1);
        check_eq("single_done_owner", owner, who);
        step();
        check_quiet("single_end");
        check_eq("single_bits_left", exp_bits.size(), 32'd0);
    endtask

    task automatic check_period(input string tag, input int n);
        check_eq({tag, "_grants"}, gnt_cyc.size(), n);
        for (int i = 1; i < gnt_cyc.size(); i++)
            check_eq({tag, "_period"}, gnt_cyc[i] - gnt_cyc[i-1], FRAME);
    endtask

    initial begin
        clr = 1'b0;
        #1;
        check_quiet("por");
        step();
        step();
        check_quiet("por_hold");
        clr = 1'b1;
        step();
        check_quiet("idle");

        single(1'b0, 4'b1011);
        single(1'b0, 4'b0111);
        single(1'b0, 4'b0110);

        // Tie straight after reset: 0, then 1, then 0 again.
        do_reset();
        gnt_cyc.delete();
        done_ref = n_done;
        push_frame(1'b0, 4'hA);
        push_frame(1'b1, 4'h5);
        push_frame(1'b0, 4'hA);
        req0 = 1'b1; din0 = 4'hA;
        req1 = 1'b1; din1 = 4'h5;
        repeat (2 * FRAME + 1) step();
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (FRAME - 1) step();
        check_quiet("tie_end");
        check_period("tie", 3);
        check_eq("tie_dones", n_done - done_ref, 32'd3);

        // Lone requester held continuously.
        gnt_cyc.delete();
        done_ref = n_done;
        repeat (3) push_frame(1'b1, 4'hC);
        req1 = 1'b1; din1 = 4'hC;
        repeat (2 * FRAME + 1) step();
        req1 = 1'b0;
        repeat (FRAME - 1) step();
        check_quiet("lone_end");
        check_period("lone", 3);
        check_eq("lone_dones", n_done - done_ref, 32'd3);

        // req1 pulsed only while shifting must be ignored.
        push_frame(1'b0, 4'h3);
        req0 = 1'b1; din0 = 4'h3;
        step();
        req0 = 1'b0;
        req1 = 1'b1; din1 = 4'hF;
        step();
        check_eq("ign_busy", busy, 32'd1);
        req1 = 1'b0;
        repeat (FRAME - 4) begin
            step();
            check_eq("ign_busy", busy, 32'd1);
        end
        step();
        check_eq("ign_done", done, 32'd1);
        check_eq("ign_busy_done", busy, 32'd1);
        repeat (3) step();
        check_quiet("ign_end");

        // Reset after the second bit of a frame aborts it silently.
        exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b1);
        exp_gnt.push_back(1'b0);
        req0 = 1'b1; din0 = 4'hF;
        step();
        req0 = 1'b0;
        step();
        done_ref = n_done;
        clr = 1'b0;
        #1;
        check_quiet("midrst");
        check_eq("midrst_owner", owner, 32'd0);
        check_eq("midrst_bits_left", exp_bits.size(), 32'd0);
        step();
        step();
        check_eq("midrst_no_done", n_done - done_ref, 32'd0);
        req1 = 1'b1; din1 = 4'h6;
        push_frame(1'b1, 4'h6);
        clr = 1'b1;
        step();
        check_eq("midrst_regrant", {gnt1, gnt0}, 32'd2);
        req1 = 1'b0;
        repeat (FRAME - 1) step();
        check_quiet("midrst_end");
        check_eq("midrst_dones", n_done - done_ref, 32'd1);

        check_eq("bits_left", exp_bits.size(), 32'd0);
        check_eq("gnts_left", exp_gnt.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
